// File: rtl/exc_commit_ctrl_pkg.sv
// Shared definitions for the commit-side exception/ERET controller:
// ExcCodes, ex/wb_exc bit indices, FSM encoding and the default vector.
package exc_commit_ctrl_pkg;

   localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

   localparam logic [4:0] EXCCODE_ADEL = 5'h04;
   localparam logic [4:0] EXCCODE_ADES = 5'h05;
   localparam logic [4:0] EXCCODE_SYS  = 5'h08;
   localparam logic [4:0] EXCCODE_BP   = 5'h09;
   localparam logic [4:0] EXCCODE_RI   = 5'h0A;
   localparam logic [4:0] EXCCODE_OV   = 5'h0C;

   localparam int EX_W    = 6;
   localparam int EX_ADEL = 0;
   localparam int EX_ADES = 1;
   localparam int EX_SYS  = 2;
   localparam int EX_BP   = 3;
   localparam int EX_RI   = 4;
   localparam int EX_OV   = 5;

   localparam int WB_W      = 7;
   localparam int WB_ADEL_F = 0;
   localparam int WB_ADEL_L = 1;
   localparam int WB_ADES   = 2;
   localparam int WB_SYS    = 3;
   localparam int WB_BP     = 4;
   localparam int WB_RI     = 5;
   localparam int WB_OV     = 6;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_REDIRECT = 1'b1
   } state_e;

endpackage

// File: rtl/exc_commit_ctrl_prio_enc.sv
// exc_prio_enc: 7-flag to one-hot 6-bit exception priority encoder.
// Also reports whether the winner is a fetch or a data address fault.
module exc_prio_enc
   import exc_commit_ctrl_pkg::*;
(
   input  logic [WB_W-1:0] raw,
   output logic [EX_W-1:0] ex,
   output logic            fetch_fault,
   output logic            data_fault
);

   logic [6:0] prio;
   logic [6:0] win;

   // Reorder so bit 0 is highest priority, then isolate the lowest set bit.
   assign prio = {raw[WB_ADES], raw[WB_ADEL_L], raw[WB_OV], raw[WB_BP],
                  raw[WB_SYS], raw[WB_RI], raw[WB_ADEL_F]};
   assign win  = prio & (~prio + 7'd1);

   always_comb begin
      ex          = '0;
      fetch_fault = 1'b0;
      data_fault  = 1'b0;
      unique case (1'b1)
         win[0]: begin
            ex[EX_ADEL] = 1'b1;
            fetch_fault = 1'b1;
         end
         win[1]: ex[EX_RI]  = 1'b1;
         win[2]: ex[EX_SYS] = 1'b1;
         win[3]: ex[EX_BP]  = 1'b1;
         win[4]: ex[EX_OV]  = 1'b1;
         win[5]: begin
            ex[EX_ADEL] = 1'b1;
            data_fault  = 1'b1;
         end
         win[6]: begin
            ex[EX_ADES] = 1'b1;
            data_fault  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/exc_commit_ctrl.sv
// Commit-side exception/ERET controller: drives CP0, flushes, redirects fetch.
// Define EXC_BADVADDR_EN to build the BadVAddr register and port.
module exc_commit_ctrl
   import exc_commit_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
   input  logic            clock,
   input  logic            resetn,
   input  logic            wb_valid,
   input  logic [31:0]     wb_pc,
   input  logic            wb_is_branch,
   input  logic [WB_W-1:0] wb_exc,
   input  logic [31:0]     wb_badvaddr,
   input  logic            wb_eret,
   input  logic [31:0]     cp0_epc,
   output logic [EX_W-1:0] ex,
   output logic [31:0]     epc_in,
   output logic            is_bd,
   output logic            valid,
   output logic            inst_ERET,
   output logic            flush,
   output logic            redirect_valid,
   output logic [31:0]     redirect_pc,
   input  logic            redirect_ready
`ifdef EXC_BADVADDR_EN
   ,
   output logic [31:0]     badvaddr
`endif
);

   state_e      state_q, state_d;
   logic        bd_pending_q, bd_pending_d;
   logic [31:0] redirect_pc_q, redirect_pc_d;

   logic [EX_W-1:0] ex_enc;
   logic            fetch_fault;
   logic            data_fault;
   logic            live;
   logic            exc_c;
   logic            eret_c;

   exc_prio_enc u_prio (
      .raw         (wb_exc),
      .ex          (ex_enc),
      .fetch_fault (fetch_fault),
      .data_fault  (data_fault)
   );

   always_comb begin
      live      = (state_q == ST_IDLE) & wb_valid;
      exc_c     = live & (|wb_exc);
      eret_c    = live & wb_eret & ~(|wb_exc);
      is_bd     = live & bd_pending_q;
      ex        = live ? ex_enc : '0;
      epc_in    = '0;
      if (live)
         epc_in = bd_pending_q ? (wb_pc - 32'd4) : wb_pc;
      valid          = live;
      inst_ERET      = eret_c;
      redirect_valid = (state_q == ST_REDIRECT);
      flush          = exc_c | eret_c | redirect_valid;
      redirect_pc    = redirect_pc_q;
   end

   always_comb begin
      state_d       = state_q;
      bd_pending_d  = bd_pending_q;
      redirect_pc_d = redirect_pc_q;
      unique case (state_q)
         ST_IDLE: begin
            if (live)
               bd_pending_d = wb_is_branch & ~exc_c & ~eret_c;
            if (exc_c) begin
               redirect_pc_d = EXC_VECTOR;
               state_d       = ST_REDIRECT;
            end else if (eret_c) begin
               redirect_pc_d = cp0_epc;
               state_d       = ST_REDIRECT;
            end
         end
         ST_REDIRECT: begin
            if (redirect_ready)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q       <= ST_IDLE;
         bd_pending_q  <= 1'b0;
         redirect_pc_q <= '0;
      end else begin
         state_q       <= state_d;
         bd_pending_q  <= bd_pending_d;
         redirect_pc_q <= redirect_pc_d;
      end
   end

`ifdef EXC_BADVADDR_EN
   logic [31:0] badvaddr_q, badvaddr_d;

   always_comb begin
      badvaddr_d = badvaddr_q;
      if (live & fetch_fault)
         badvaddr_d = wb_pc;
      else if (live & data_fault)
         badvaddr_d = wb_badvaddr;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         badvaddr_q <= '0;
      else
         badvaddr_q <= badvaddr_d;
   end

   assign badvaddr = badvaddr_q;
`else
   logic unused_bva;
   assign unused_bva = ^{wb_badvaddr, fetch_fault, data_fault};
`endif

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Directed self-checking bench for exc_commit_ctrl.
// Define EXC_BADVADDR_EN to also exercise the BadVAddr register.
module tb_exc_commit_ctrl;

   logic        clock;
   logic        resetn;
   logic        wb_valid;
   logic [31:0] wb_pc;
   logic        wb_is_branch;
   logic [6:0]  wb_exc;
   logic [31:0] wb_badvaddr;
   logic        wb_eret;
   logic [31:0] cp0_epc;
   logic [5:0]  ex;
   logic [31:0] epc_in;
   logic        is_bd;
   logic        valid;
   logic        inst_ERET;
   logic        flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        redirect_ready;
`ifdef EXC_BADVADDR_EN
   logic [31:0] badvaddr;
`endif

   int errors = 0;
   int checks = 0;

   exc_commit_ctrl dut (
      .clock          (clock),
      .resetn         (resetn),
      .wb_valid       (wb_valid),
      .wb_pc          (wb_pc),
      .wb_is_branch   (wb_is_branch),
      .wb_exc         (wb_exc),
      .wb_badvaddr    (wb_badvaddr),
      .wb_eret        (wb_eret),
      .cp0_epc        (cp0_epc),
      .ex             (ex),
      .epc_in         (epc_in),
      .is_bd          (is_bd),
      .valid          (valid),
      .inst_ERET      (inst_ERET),
      .flush          (flush),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .redirect_ready (redirect_ready)
`ifdef EXC_BADVADDR_EN
      ,
      .badvaddr       (badvaddr)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wb(input logic v, input logic [31:0] pc,
                     input logic br, input logic [6:0] e,
                     input logic er);
      wb_valid     = v;
      wb_pc        = pc;
      wb_is_branch = br;
      wb_exc       = e;
      wb_eret      = er;
   endtask

   initial begin
      resetn         = 1'b0;
      redirect_ready = 1'b0;
      wb_badvaddr    = '0;
      cp0_epc        = '0;
      wb(0, 0, 0, 0, 0);
      #3;
      chk("rst_rv", {31'd0, redirect_valid}, 0);
      chk("rst_flush", {31'd0, flush}, 0);
      chk("rst_rpc", redirect_pc, 0);
      chk("rst_valid", {31'd0, valid}, 0);
      chk("rst_ex", {26'd0, ex}, 0);
      @(negedge clock);
      resetn = 1'b1;

      // Sys at 0x1000
      tick();
      wb(1, 32'h1000, 0, 7'b0001000, 0);
      #1;
      chk("sys_ex", {26'd0, ex}, 32'h04);
      chk("sys_epc", epc_in, 32'h1000);
      chk("sys_bd", {31'd0, is_bd}, 0);
      chk("sys_flush", {31'd0, flush}, 1);
      chk("sys_valid", {31'd0, valid}, 1);
      tick();
      wb(0, 0, 0, 0, 0);
      redirect_ready = 1'b1;
      #1;
      chk("sys_rv", {31'd0, redirect_valid}, 1);
      chk("sys_rpc", redirect_pc, 32'hBFC0_0380);
      chk("sys_flush2", {31'd0, flush}, 1);
      tick();
      redirect_ready = 1'b0;
      #1;
      chk("sys_idle_rv", {31'd0, redirect_valid}, 0);
      chk("sys_idle_fl", {31'd0, flush}, 0);

      // Branch then Ov in delay slot
      tick();
      wb(1, 32'h2000, 1, 0, 0);
      #1;
      chk("br_bd", {31'd0, is_bd}, 0);
      chk("br_valid", {31'd0, valid}, 1);
      chk("br_flush", {31'd0, flush}, 0);
      tick();
      wb(1, 32'h2004, 0, 7'b1000000, 0);
      #1;
      chk("ov_bd", {31'd0, is_bd}, 1);
      chk("ov_epc", epc_in, 32'h2000);
      chk("ov_ex", {26'd0, ex}, 32'h20);
      tick();
      wb(0, 0, 0, 0, 0);
      redirect_ready = 1'b1;
      #1;
      chk("ov_rv", {31'd0, redirect_valid}, 1);
      tick();
      redirect_ready = 1'b0;

      // ERET with stalled redirect
      wb(1, 32'h3010, 0, 0, 1);
      cp0_epc = 32'h3008;
      #1;
      chk("eret_inst", {31'd0, inst_ERET}, 1);
      chk("eret_valid", {31'd0, valid}, 1);
      chk("eret_ex", {26'd0, ex}, 0);
      chk("eret_flush", {31'd0, flush}, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         wb(1, 32'h3100, 0, 7'b0001000, 0);
         cp0_epc = '0;
         #1;
         chk("eret_hold_rv", {31'd0, redirect_valid}, 1);
         chk("eret_hold_pc", redirect_pc, 32'h3008);
         chk("eret_hold_val", {31'd0, valid}, 0);
         chk("eret_hold_ex", {26'd0, ex}, 0);
         chk("eret_hold_fl", {31'd0, flush}, 1);
      end
      tick();
      redirect_ready = 1'b1;
      #1;
      chk("eret_hs_rv", {31'd0, redirect_valid}, 1);
      chk("eret_hs_fl", {31'd0, flush}, 1);
      tick();
      redirect_ready = 1'b0;
      wb(1, 32'h3200, 0, 0, 0);
      #1;
      chk("eret_after_rv", {31'd0, redirect_valid}, 0);
      chk("eret_after_fl", {31'd0, flush}, 0);
      chk("eret_after_val", {31'd0, valid}, 1);

      // RI|Ov|AdES with ERET: RI wins, no ERET
      tick();
      wb(1, 32'h3300, 0, 7'b1100100, 1);
      #1;
      chk("mix_ex", {26'd0, ex}, 32'h10);
      chk("mix_eret", {31'd0, inst_ERET}, 0);
      chk("mix_flush", {31'd0, flush}, 1);
      tick();
      wb(0, 0, 0, 0, 0);
      redirect_ready = 1'b1;
      #1;
      chk("mix_rpc", redirect_pc, 32'hBFC0_0380);
      tick();
      redirect_ready = 1'b0;

      // AdEL-fetch beats RI
      wb(1, 32'h3400, 0, 7'b0100001, 0);
      #1;
      chk("adelf_ex", {26'd0, ex}, 32'h01);
      tick();
      wb(0, 0, 0, 0, 0);
      redirect_ready = 1'b1;
`ifdef EXC_BADVADDR_EN
      #1;
      chk("adelf_bva", badvaddr, 32'h3400);
`endif
      tick();
      redirect_ready = 1'b0;

      // AdEL-load then AdES
      wb(1, 32'h4000, 0, 7'b0000010, 0);
      wb_badvaddr = 32'h3;
      #1;
      chk("adell_ex", {26'd0, ex}, 32'h01);
      tick();
      wb(0, 0, 0, 0, 0);
      redirect_ready = 1'b1;
`ifdef EXC_BADVADDR_EN
      #1;
      chk("adell_bva", badvaddr, 32'h3);
`endif
      tick();
      redirect_ready = 1'b0;
      wb(1, 32'h4010, 0, 7'b0000100, 0);
      wb_badvaddr = 32'h7;
      #1;
      chk("ades_ex", {26'd0, ex}, 32'h02);
      chk("ades_epc", epc_in, 32'h4010);
      tick();
      wb(0, 0, 0, 0, 0);
      redirect_ready = 1'b1;
`ifdef EXC_BADVADDR_EN
      #1;
      chk("ades_bva", badvaddr, 32'h7);
`endif
      tick();
      redirect_ready = 1'b0;

      // Reset mid-REDIRECT
      wb(1, 32'h5000, 1, 0, 0);
      tick();
      wb(1, 32'h5004, 0, 7'b0010000, 0);
      #1;
      chk("bp_bd", {31'd0, is_bd}, 1);
      chk("bp_ex", {26'd0, ex}, 32'h08);
      chk("bp_epc", epc_in, 32'h5000);
      tick();
      wb(0, 0, 0, 0, 0);
      #1;
      chk("rr_rv_pre", {31'd0, redirect_valid}, 1);
      resetn = 1'b0;
      #1;
      chk("rr_rv", {31'd0, redirect_valid}, 0);
      chk("rr_flush", {31'd0, flush}, 0);
      chk("rr_rpc", redirect_pc, 0);
      @(negedge clock);
      resetn = 1'b1;
      tick();
      wb(1, 32'h6000, 0, 7'b0001000, 0);
      #1;
      chk("post_bd", {31'd0, is_bd}, 0);
      chk("post_epc", epc_in, 32'h6000);
      chk("post_ex", {26'd0, ex}, 32'h04);
      chk("post_flush", {31'd0, flush}, 1);
      tick();
      wb(0, 0, 0, 0, 0);
      #1;
      chk("post_rpc", redirect_pc, 32'hBFC0_0380);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
